hwrandom_conditioner: RTL and testbench

Parametrised successor to the single-bank ring-oscillator core. It samples NUM_CHANNELS synchronised raw entropy bits and XOR-combines them. Optional von Neumann whitening and a repetition-count health test are applied before the bits are packed into WORD_WIDTH words. Words are buffered in a FIFO and streamed out as bytes over a valid/ready interface to the UART transmitter. The last completed word is exported for the hex display.

---
 rtl/hwrandom_conditioner.sv | 193 +++++++++++++++++++
 tb/tb_hwrandom_conditioner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwrandom_conditioner.sv
// Entropy conditioner: XOR-combines raw channels, optional von Neumann whitening and a
// repetition-count health test, packs bits into words, buffers them and streams bytes out.
module hwrandom_conditioner #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SAMPLE_DIV   = 16,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned REP_LIMIT    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] raw_bits,
    input  logic                    mode,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   disp_word,
    output logic                    health_fail,
    output logic [15:0]             dropped_words
);

    localparam int unsigned DivW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CntW     = $clog2(WORD_WIDTH + 1);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned NumBytes = WORD_WIDTH / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    logic [DivW-1:0]       div_q, div_d;
    logic [7:0]            run_q, run_d;
    logic                  last_s_q, last_s_d;
    logic                  health_fail_q, health_fail_d;
    logic                  mode_q, mode_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  pair_q, pair_d;
    logic                  first_q, first_d;
    logic [WORD_WIDTH-1:0] disp_q, disp_d;
    logic [15:0]           dropped_q, dropped_d;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PtrW:0]         wptr_q, wptr_d, rptr_q, rptr_d, fill;
    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;

    logic                  tick, s, complete, empty, full, push, pop, drop, last_byte;
    logic [WORD_WIDTH-1:0] head_word;

    assign tick     = (div_q == DivW'(SAMPLE_DIV - 1));
    assign s        = ^raw_bits;
    assign complete = (bit_cnt_q == CntW'(WORD_WIDTH));
    assign fill     = wptr_q - rptr_q;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    // A pop on the same edge frees the slot the completed word is written into.
    assign push     = complete && !health_fail_q && (!full || pop);
    assign drop     = complete && !health_fail_q && full && !pop;

    always_comb begin
        div_d         = tick ? '0 : div_q + DivW'(1);
        run_d         = run_q;
        last_s_d      = last_s_q;
        health_fail_d = health_fail_q;
        if (tick) begin
            last_s_d = s;
            if (run_q == 8'd0 || s != last_s_q) begin
                run_d = 8'd1;
            end else if (run_q < 8'(REP_LIMIT)) begin
                run_d = run_q + 8'd1;
            end
            if (run_d == 8'(REP_LIMIT)) begin
                health_fail_d = 1'b1;
            end
        end
    end

    always_comb begin
        mode_d    = mode;
        word_d    = word_q;
        bit_cnt_d = complete ? '0 : bit_cnt_q;
        pair_d    = pair_q;
        first_d   = first_q;
        if (mode != mode_q) begin
            word_d    = '0;
            bit_cnt_d = '0;
            pair_d    = 1'b0;
        end else if (tick && !health_fail_q && !complete) begin
            if (!mode) begin
                word_d    = {word_q[WORD_WIDTH-2:0], s};
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end else if (!pair_q) begin
                first_d = s;
                pair_d  = 1'b1;
            end else begin
                pair_d = 1'b0;
                if (first_q != s) begin
                    word_d    = {word_q[WORD_WIDTH-2:0], first_q};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = pop ? rptr_q + (PtrW+1)'(1) : rptr_q;
        disp_d = disp_q;
        if (push) begin
            mem_d[wptr_q[PtrW-1:0]] = word_q;
            wptr_d                  = wptr_q + (PtrW+1)'(1);
            disp_d                  = word_q;
        end
        dropped_d = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
    end

    // The word being sent stays at the FIFO head and is freed only by its last byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: if (!empty) state_d = StLoad;
            StLoad: begin
                state_d = StSend;
                idx_d   = '0;
            end
            StSend: begin
                if (out_ready) begin
                    if (last_byte) begin
                        idx_d   = '0;
                        state_d = (fill > (PtrW+1)'(1)) ? StSend : StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_byte = (idx_q == IdxW'(NumBytes - 1));
        out_valid = (state_q == StSend);
        head_word = mem_q[rptr_q[PtrW-1:0]];
        out_byte  = out_valid ? head_word[{idx_q, 3'b000} +: 8] : 8'h00;
        pop       = out_valid && out_ready && last_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            run_q         <= '0;
            last_s_q      <= 1'b0;
            health_fail_q <= 1'b0;
            mode_q        <= 1'b0;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            pair_q        <= 1'b0;
            first_q       <= 1'b0;
            disp_q        <= '0;
            dropped_q     <= '0;
            mem_q         <= '{default: '0};
            wptr_q        <= '0;
            rptr_q        <= '0;
            state_q       <= StIdle;
            idx_q         <= '0;
        end else begin
            div_q         <= div_d;
            run_q         <= run_d;
            last_s_q      <= last_s_d;
            health_fail_q <= health_fail_d;
            mode_q        <= mode_d;
            word_q        <= word_d;
            bit_cnt_q     <= bit_cnt_d;
            pair_q        <= pair_d;
            first_q       <= first_d;
            disp_q        <= disp_d;
            dropped_q     <= dropped_d;
            mem_q         <= mem_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
        end
    end

    assign disp_word     = disp_q;
    assign health_fail   = health_fail_q;
    assign dropped_words = dropped_q;

endmodule

// File: tb/tb_hwrandom_conditioner.sv
// Scenario bench for hwrandom_conditioner: expected bytes are queued as words are driven and
// matched against bytes captured on each accepted handshake.
module tb_hwrandom_conditioner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  raw_bits = 4'h0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic [15:0] disp_word;
    logic        health_fail;
    logic [15:0] dropped_words;

    int          n_checks = 0;
    int          n_pass = 0;
    int          phase = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    hwrandom_conditioner #(
        .NUM_CHANNELS(4),
        .SAMPLE_DIV  (4),
        .WORD_WIDTH  (16),
        .FIFO_DEPTH  (2),
        .REP_LIMIT   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_bits     (raw_bits),
        .mode         (mode),
        .out_byte     (out_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .disp_word    (disp_word),
        .health_fail  (health_fail),
        .dropped_words(dropped_words)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) rx_q.push_back(out_byte);
    end

    // phase tracks the divider: a sample is taken on every edge that brings phase to 0.
    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
    endtask

    task automatic tick(input logic s);
        logic [2:0] r;
        r = 3'($urandom_range(0, 7));
        raw_bits = {s ^ (^r), r};
        step();
        while (phase != 0) step();
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) tick(w[i]);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        phase = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_rx(input int limit);
        int waited = 0;
        while (rx_q.size() < exp_q.size() && waited < limit) begin
            step();
            waited++;
        end
    endtask

    task automatic test_reset();
        mode = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", out_byte); else n_pass++;
        n_checks++; if (disp_word !== 16'h0) $display("FAIL reset_disp: got %h want 0000", disp_word); else n_pass++;
        n_checks++; if (health_fail !== 1'b0) $display("FAIL reset_health: got %0b want 0", health_fail); else n_pass++;
        n_checks++; if (dropped_words !== 16'h0) $display("FAIL reset_dropped: got %h want 0000", dropped_words); else n_pass++;
    endtask

    task automatic test_mode0();
        logic [15:0] w;
        logic [7:0]  e, a;
        w = 16'hCCCC;
        mode = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        exp_q.push_back(8'hCC);
        exp_q.push_back(8'hCC);
        send_word(w);
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL m0_lat1: got %0b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL m0_lat2: got %0b want 0", out_valid); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL m0_lat3: got %0b want 1", out_valid); else n_pass++;
        wait_rx(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) $display("FAIL m0_byte: got none want %h", e);
            else begin
                a = rx_q.pop_front();
                if (a !== e) $display("FAIL m0_byte: got %h want %h", a, e); else n_pass++;
            end
        end
        n_checks++; if (rx_q.size() != 0) $display("FAIL m0_extra: got %0d bytes want 0", rx_q.size()); else n_pass++;
        n_checks++; if (disp_word !== 16'hCCCC) $display("FAIL m0_disp: got %h want cccc", disp_word); else n_pass++;
        n_checks++; if (health_fail !== 1'b0) $display("FAIL m0_health: got %0b want 0", health_fail); else n_pass++;
    endtask

    task automatic test_whiten();
        logic [7:0] e, a;
        logic [7:0] pat;
        pat = 8'b0111_1000;
        mode = 1'b1;
        out_ready = 1'b0;
        apply_reset();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        for (int g = 0; g < 8; g++) begin
            for (int i = 7; i >= 0; i--) tick(pat[i]);
        end
        out_ready = 1'b1;
        wait_rx(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) $display("FAIL vn_byte: got none want %h", e);
            else begin
                a = rx_q.pop_front();
                if (a !== e) $display("FAIL vn_byte: got %h want %h", a, e); else n_pass++;
            end
        end
        n_checks++; if (disp_word !== 16'h5555) $display("FAIL vn_disp: got %h want 5555", disp_word); else n_pass++;
    endtask

    task automatic test_health();
        int seen = 0;
        mode = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        raw_bits = 4'b0000;
        for (int t = 0; t < 7; t++) repeat (4) step();
        n_checks++; if (health_fail !== 1'b0) $display("FAIL hf_tick7: got %0b want 0", health_fail); else n_pass++;
        repeat (4) step();
        n_checks++; if (health_fail !== 1'b1) $display("FAIL hf_tick8: got %0b want 1", health_fail); else n_pass++;
        for (int t = 0; t < 200; t++) begin
            repeat (4) begin
                step();
                if (out_valid) seen++;
            end
        end
        n_checks++; if (seen != 0) $display("FAIL hf_no_output: got %0d valid cycles want 0", seen); else n_pass++;
        n_checks++; if (health_fail !== 1'b1) $display("FAIL hf_sticky: got %0b want 1", health_fail); else n_pass++;
        apply_reset();
        n_checks++; if (health_fail !== 1'b0) $display("FAIL hf_reset: got %0b want 0", health_fail); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] e, a;
        mode = 1'b0;
        out_ready = 1'b0;
        apply_reset();
        send_word(16'hCCCC);
        send_word(16'hF0F0);
        send_word(16'h1234);
        step();
        step();
        n_checks++; if (dropped_words !== 16'd1) $display("FAIL ov_dropped: got %0d want 1", dropped_words); else n_pass++;
        n_checks++; if (disp_word !== 16'hF0F0) $display("FAIL ov_disp: got %h want f0f0", disp_word); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL ov_stall_valid: got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (out_byte !== 8'hCC) $display("FAIL ov_stall_byte: got %h want cc", out_byte); else n_pass++;
        exp_q.push_back(8'hCC);
        exp_q.push_back(8'hCC);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hF0);
        out_ready = 1'b1;
        wait_rx(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) $display("FAIL ov_byte: got none want %h", e);
            else begin
                a = rx_q.pop_front();
                if (a !== e) $display("FAIL ov_byte: got %h want %h", a, e); else n_pass++;
            end
        end
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ov_drained: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (rx_q.size() != 0) $display("FAIL ov_extra: got %0d bytes want 0", rx_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, a;
        mode = 1'b0;
        out_ready = 1'b0;
        apply_reset();
        send_word(16'hA55A);
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %0b want 1", out_valid); else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        phase = 0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (disp_word !== 16'h0) $display("FAIL rm_disp: got %h want 0000", disp_word); else n_pass++;
        n_checks++; if (dropped_words !== 16'h0) $display("FAIL rm_dropped: got %h want 0000", dropped_words); else n_pass++;
        out_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_fifo_empty: got %0b want 0", out_valid); else n_pass++;
        rx_q.delete();
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        send_word(16'h6996);
        wait_rx(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) $display("FAIL rm_byte: got none want %h", e);
            else begin
                a = rx_q.pop_front();
                if (a !== e) $display("FAIL rm_byte: got %h want %h", a, e); else n_pass++;
            end
        end
        n_checks++; if (disp_word !== 16'h6996) $display("FAIL rm_disp_after: got %h want 6996", disp_word); else n_pass++;
    endtask

    task automatic test_mode_switch();
        logic [9:0]  old_bits;
        logic [15:0] w;
        logic [7:0]  e, a;
        old_bits = 10'b10_1100_1011;
        w = 16'hC3A5;
        mode = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        for (int i = 9; i >= 0; i--) tick(old_bits[i]);
        mode = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        for (int i = 15; i >= 0; i--) begin
            tick(w[i]);
            tick(~w[i]);
        end
        wait_rx(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) $display("FAIL ms_byte: got none want %h", e);
            else begin
                a = rx_q.pop_front();
                if (a !== e) $display("FAIL ms_byte: got %h want %h", a, e); else n_pass++;
            end
        end
        n_checks++; if (disp_word !== 16'hC3A5) $display("FAIL ms_disp: got %h want c3a5", disp_word); else n_pass++;
        n_checks++; if (rx_q.size() != 0) $display("FAIL ms_extra: got %0d bytes want 0", rx_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_whiten();
        test_health();
        test_overflow();
        test_reset_mid();
        test_mode_switch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
